// File: rtl/interp_divider_pkg.sv
// Shared widths and the per-stage pipeline record for the SPR interpolation
// divider back-end.
package spr_pkg;

    localparam int DB_W   = 19;
    localparam int IV_W   = 8;
    localparam int PX_W   = 11;
    localparam int Q_W    = 11;
    localparam int PX_MAX = 2047;
    localparam int LAT    = Q_W + 2;

    // Everything one pixel carries while its quotient is being resolved.
    // r is one bit wider than the divisor so the shifted remainder never
    // overflows before the compare.
    typedef struct packed {
        logic [IV_W:0]     r;
        logic [Q_W-1:0]    tail;
        logic [Q_W-1:0]    q;
        logic [IV_W-1:0]   d;
        logic [PX_W-1:0]   lobound;
        logic              act;
        logic              dz;
        logic              ovf;
        logic              hs;
        logic              vs;
    } div_stage_t;

endpackage

// File: rtl/interp_divider_if.sv
// Pixel stream bundle between the interpolator front-end and the divider.
interface interp_divider_if;
    import spr_pkg::*;

    logic              i_hs;
    logic              i_vs;
    logic [IV_W-1:0]   interval;
    logic [DB_W-1:0]   delta_bound;
    logic [PX_W-1:0]   lobound;
    logic [PX_W-1:0]   pixel_out;
    logic              o_valid;
    logic              o_hs;
    logic              o_vs;

    modport master (
        output i_hs, i_vs, interval, delta_bound, lobound,
        input  pixel_out, o_valid, o_hs, o_vs
    );

    modport slave (
        input  i_hs, i_vs, interval, delta_bound, lobound,
        output pixel_out, o_valid, o_hs, o_vs
    );

endinterface

// File: rtl/interp_divider_div_stage.sv
// One registered restoring-division step. STAGE selects which quotient bit
// (MSB first) this instance resolves; all side-band fields ride along.
module div_stage
    import spr_pkg::*;
#(
    parameter int STAGE = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  div_stage_t din,
    output div_stage_t dout
);

    localparam int BIT = Q_W - 1 - STAGE;

    logic [IV_W:0] r_shift;
    logic [IV_W:0] d_ext;
    logic          take;
    div_stage_t    nxt;

    // Shift in the next dividend bit and subtract the divisor when it fits
    always_comb begin
        r_shift = {din.r[IV_W-1:0], din.tail[BIT]};
        d_ext   = {1'b0, din.d};
        take    = (r_shift >= d_ext);
        nxt     = din;
        if (take) begin
            nxt.r = r_shift - d_ext;
        end else begin
            nxt.r = r_shift;
        end
        nxt.q[BIT] = take;
    end

    // Stage register, cleared so a reset drops the pixel in flight here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= '0;
        end else begin
            dout <= nxt;
        end
    end

endmodule

// File: rtl/interp_divider.sv
// SPR interpolation back-end: pixel_out = lobound + floor(delta_bound/interval),
// saturated to PX_W bits. Fully pipelined, one pixel per clock, syncs delayed
// by the same LAT so downstream timing is untouched.
module interp_divider
    import spr_pkg::*;
#(
    parameter int INTERVAL_SKEW = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    interp_divider_if.slave  bus
);

    logic [IV_W-1:0] skew_q [INTERVAL_SKEW];
    logic [IV_W-1:0] d_al;
    logic [IV_W-1:0] db_hi;
    div_stage_t      s0_nxt;
    div_stage_t      stg [Q_W+1];
    div_stage_t      last;
    logic [Q_W-1:0]  q_sel;
    logic [PX_W:0]   sum;
    logic            unused_last;

    // Clamp an (PX_W+1)-bit sum to the largest pixel code.
    function automatic logic [PX_W-1:0] sat_px(input logic [PX_W:0] s);
        return s[PX_W] ? {PX_W{1'b1}} : s[PX_W-1:0];
    endfunction

    // Delay interval so it lines up with the delta_bound it divides
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < INTERVAL_SKEW; i++) begin
                skew_q[i] <= '0;
            end
        end else begin
            skew_q[0] <= bus.interval;
            for (int i = 1; i < INTERVAL_SKEW; i++) begin
                skew_q[i] <= skew_q[i-1];
            end
        end
    end

    assign d_al  = skew_q[INTERVAL_SKEW-1];
    assign db_hi = bus.delta_bound[DB_W-1:Q_W];

    // Stage 0 record: the high dividend bits seed the remainder; if they
    // already reach the divisor the quotient cannot fit in Q_W bits
    always_comb begin
        s0_nxt         = '0;
        s0_nxt.r       = {1'b0, db_hi};
        s0_nxt.tail    = bus.delta_bound[Q_W-1:0];
        s0_nxt.d       = d_al;
        s0_nxt.lobound = bus.lobound;
        s0_nxt.act     = bus.i_hs & bus.i_vs;
        s0_nxt.dz      = (d_al == '0);
        s0_nxt.ovf     = (d_al != '0) && (db_hi >= d_al);
        s0_nxt.hs      = bus.i_hs;
        s0_nxt.vs      = bus.i_vs;
    end

    // Capture register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg[0] <= '0;
        end else begin
            stg[0] <= s0_nxt;
        end
    end

    for (genvar g = 0; g < Q_W; g++) begin : g_stage
        div_stage #(.STAGE(g)) u_stage (
            .clk  (clk),
            .rst_n(rst_n),
            .din  (stg[g]),
            .dout (stg[g+1])
        );
    end

    assign last = stg[Q_W];

    // Quotient select: divide-by-zero gives a flat region and wins over overflow
    always_comb begin
        q_sel = last.q;
        if (last.dz) begin
            q_sel = '0;
        end else if (last.ovf) begin
            q_sel = '1;
        end
        sum = {1'b0, last.lobound} + {{(PX_W+1-Q_W){1'b0}}, q_sel};
    end

    // Remainder and divisor are spent once the last bit is resolved
    assign unused_last = ^{last.r, last.tail, last.d};

    // Output register: blanked pixels are forced to zero and marked invalid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.pixel_out <= '0;
            bus.o_valid   <= 1'b0;
            bus.o_hs      <= 1'b0;
            bus.o_vs      <= 1'b0;
        end else begin
            bus.pixel_out <= last.act ? sat_px(sum) : '0;
            bus.o_valid   <= last.act;
            bus.o_hs      <= last.hs;
            bus.o_vs      <= last.vs;
        end
    end

endmodule

// File: tb/tb_interp_divider.sv
// Directed bench for interp_divider: basic, divide-by-zero/overflow/saturation
// corners, blanking, a random stream and mid-frame reset.
module tb_interp_divider;
    import spr_pkg::*;

    logic clk;
    logic rst_n;

    interp_divider_if bus ();

    interp_divider #(.INTERVAL_SKEW(1)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    int iv_a  [32];
    int db_a  [32];
    int lb_a  [32];
    bit hs_a  [32];
    bit vs_a  [32];
    int ex_px [32];
    int n_px;
    string cur_tag;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs(input string tag, input int px, input bit vld, input bit hs, input bit vs);
        chk({tag, ".px"},  32'(bus.pixel_out), 32'(px));
        chk({tag, ".vld"}, 32'(bus.o_valid),   32'(vld));
        chk({tag, ".hs"},  32'(bus.o_hs),      32'(hs));
        chk({tag, ".vs"},  32'(bus.o_vs),      32'(vs));
    endtask

    task automatic zero_inputs();
        bus.interval    = '0;
        bus.delta_bound = '0;
        bus.lobound     = '0;
        bus.i_hs        = 1'b0;
        bus.i_vs        = 1'b0;
    endtask

    task automatic add_px(input int iv, input int db, input int lb, input bit hs, input bit vs, input int px);
        iv_a[n_px]  = iv;
        db_a[n_px]  = db;
        lb_a[n_px]  = lb;
        hs_a[n_px]  = hs;
        vs_a[n_px]  = vs;
        ex_px[n_px] = px;
        n_px++;
    endtask

    function automatic int ref_px(input int iv, input int db, input int lb);
        int q;
        q = (iv == 0) ? 0 : db / iv;
        if (q > 2047) q = 2047;
        if (lb + q > 2047) return 2047;
        return lb + q;
    endfunction

    // interval of pixel k is driven one cycle before its delta_bound; a
    // delta_bound driven in iteration j shows up at the output in iteration j+LAT
    task automatic run_stream(input int stop_at);
        int total;
        int k;
        total = n_px + LAT + 1;
        for (int c = 0; c < total && c < stop_at; c++) begin
            tick();
            k = c - (LAT + 1);
            if (k >= 0 && k < n_px) begin
                chk_outputs($sformatf("%s[%0d]", cur_tag, k), ex_px[k],
                            hs_a[k] & vs_a[k], hs_a[k], vs_a[k]);
            end else begin
                chk_outputs($sformatf("%s.idle%0d", cur_tag, c), 0, 1'b0, 1'b0, 1'b0);
            end
            bus.interval = (c < n_px) ? IV_W'(iv_a[c]) : '0;
            if (c >= 1 && c - 1 < n_px) begin
                bus.delta_bound = DB_W'(db_a[c-1]);
                bus.lobound     = PX_W'(lb_a[c-1]);
                bus.i_hs        = hs_a[c-1];
                bus.i_vs        = vs_a[c-1];
            end else begin
                bus.delta_bound = '0;
                bus.lobound     = '0;
                bus.i_hs        = 1'b0;
                bus.i_vs        = 1'b0;
            end
        end
    endtask

    initial begin
        int iv;
        int db;
        int lb;

        // Reset with live-looking inputs: outputs must stay cleared
        rst_n           = 1'b0;
        bus.interval    = 8'd9;
        bus.delta_bound = 19'd4000;
        bus.lobound     = 11'd77;
        bus.i_hs        = 1'b1;
        bus.i_vs        = 1'b1;
        repeat (3) tick();
        chk_outputs("reset", 0, 1'b0, 1'b0, 1'b0);
        zero_inputs();
        tick();
        rst_n = 1'b1;

        // Basic: 1000/10 + 100
        cur_tag = "basic";
        n_px = 0;
        add_px(10, 1000, 100, 1'b1, 1'b1, 200);
        run_stream(1000);

        // Corners back to back
        cur_tag = "corner";
        n_px = 0;
        add_px(0,   5000,   321,  1'b1, 1'b1, 321);   // divide by zero
        add_px(1,   347990, 0,    1'b1, 1'b1, 2047);  // quotient overflow
        add_px(4,   80,     2040, 1'b1, 1'b1, 2047);  // sum saturation
        add_px(0,   347990, 5,    1'b1, 1'b1, 5);     // dz beats ovf
        add_px(170, 347990, 0,    1'b1, 1'b1, 2047);  // exact max quotient
        add_px(255, 43350,  7,    1'b1, 1'b1, 177);
        add_px(3,   6143,   0,    1'b1, 1'b1, 2047);  // 2047 rem 2, no ovf
        add_px(7,   100,    1000, 1'b1, 1'b1, 1014);
        add_px(1,   0,      0,    1'b1, 1'b1, 0);     // active zero pixel
        run_stream(1000);

        // Blanking: hs low for three pixels, then one with vs low
        cur_tag = "blank";
        n_px = 0;
        add_px(5, 500, 10, 1'b1, 1'b1, 110);
        add_px(5, 500, 11, 1'b1, 1'b1, 111);
        add_px(5, 500, 12, 1'b1, 1'b1, 112);
        add_px(5, 500, 13, 1'b0, 1'b1, 0);
        add_px(5, 500, 14, 1'b0, 1'b1, 0);
        add_px(5, 500, 15, 1'b0, 1'b1, 0);
        add_px(5, 500, 16, 1'b1, 1'b1, 116);
        add_px(5, 500, 17, 1'b1, 1'b0, 0);
        add_px(5, 500, 18, 1'b1, 1'b1, 118);
        run_stream(1000);

        // Random stream at full rate
        cur_tag = "rand";
        n_px = 0;
        for (int i = 0; i < 20; i++) begin
            iv = int'($urandom_range(1, 255));
            db = int'($urandom_range(0, 170 * iv));
            lb = int'($urandom_range(0, 2047));
            add_px(iv, db, lb, 1'b1, 1'b1, ref_px(iv, db, lb));
        end
        run_stream(1000);

        // Mid-frame reset with six pixels still in flight
        cur_tag = "prerst";
        n_px = 0;
        for (int i = 0; i < 9; i++) begin
            add_px(8, 800 + 8 * i, 50, 1'b1, 1'b1, 150 + i);
        end
        run_stream(LAT + 4);
        #2;
        rst_n = 1'b0;
        #1;
        chk_outputs("rst_async", 0, 1'b0, 1'b0, 1'b0);
        zero_inputs();
        tick();
        tick();
        chk_outputs("rst_hold", 0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // First pixel after reset: exactly LAT later, nothing stale before it
        cur_tag = "postrst";
        n_px = 0;
        add_px(12, 1200, 3, 1'b1, 1'b1, 103);
        run_stream(1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
